// File: rtl/ctrl_mem_responder.sv
// ctrl_mem_responder: on-chip word memory behind the sdram_core request interface with SDRAM-like init, latency and refresh stalls
// Optional feature macro: CTRL_RESP_RAND_STALL_EN adds 0-7 LFSR-chosen stall cycles to each request's latency
module ctrl_mem_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int WR_LATENCY     = 3,
    parameter int RD_LATENCY     = 5,
    parameter int REFRESH_PERIOD = 390,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  rdy,
    output logic                  wvalid,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] read_data
);
    localparam int B     = $clog2(DATA_WIDTH / 8);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam int RW    = $clog2(REFRESH_PERIOD + 1);
    localparam int CW    = 16;

    typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, REFRESH} state_t;

    state_t                    r_state, w_nxt;
    logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0]     r_wdata, r_rbuf, r_read_data;
    logic [CW-1:0]             r_cnt;
    logic [RW-1:0]             r_rcnt;
    logic                      r_pend, r_rdy, r_wvalid, r_rvalid;
    logic                      w_acc, w_wrap, w_done, w_pend_nxt, w_mem_we, w_unused;
    logic [MEM_ADDR_WIDTH-1:0] w_idx;
    logic [CW-1:0]             w_extra;

    // byte offset and upper address bits are don't-care, so addresses alias modulo the depth
    assign w_idx      = addr[MEM_ADDR_WIDTH+B-1:B];
    assign w_unused   = ^addr;
    assign w_acc      = r_rdy & (wr | rd);
    assign w_wrap     = (r_state != INIT) && (r_rcnt == RW'(REFRESH_PERIOD - 1));
    assign w_done     = (r_cnt == '0);
    // a wrap while already pending merges into the same refresh
    assign w_pend_nxt = w_wrap | (r_pend & ~(r_state == REFRESH && w_done));
    assign w_mem_we   = (r_state == INIT) || (r_state == WRITE && w_done);

    assign rdy       = r_rdy;
    assign wvalid    = r_wvalid;
    assign rvalid    = r_rvalid;
    assign read_data = r_read_data;

`ifdef CTRL_RESP_RAND_STALL_EN
    logic [15:0] r_lfsr;
    // free-running Fibonacci LFSR, taps 16/14/13/11
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= 16'hACE1;
        else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_extra = CW'(r_lfsr[2:0]);
`else
    assign w_extra = '0;
`endif

    // next state: acceptance beats a pending refresh, refresh follows any in-flight op
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            INIT:        w_nxt = (r_idx == '1) ? IDLE : INIT;
            IDLE:        w_nxt = w_acc ? (wr ? WRITE : READ) : (w_pend_nxt ? REFRESH : IDLE);
            WRITE, READ: w_nxt = w_done ? (w_pend_nxt ? REFRESH : IDLE) : r_state;
            REFRESH:     w_nxt = w_done ? IDLE : REFRESH;
            default:     w_nxt = INIT;
        endcase
    end

    // control registers; rdy looks at the current state so a re-issue needs latency+2 cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_cnt       <= '0;
            r_rcnt      <= '0;
            r_pend      <= 1'b0;
            r_rdy       <= 1'b0;
            r_wvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_pend   <= w_pend_nxt;
            r_rcnt   <= (r_state == INIT || w_wrap) ? '0 : r_rcnt + 1'b1;
            r_rdy    <= (r_state == IDLE || r_state == INIT) && (w_nxt == IDLE);
            r_wvalid <= (r_state == WRITE) && w_done;
            r_rvalid <= (r_state == READ) && w_done;
            if (r_state == READ && w_done) r_read_data <= r_rbuf;
            if (r_state == INIT) r_idx <= r_idx + 1'b1;
            else if (w_acc)      r_idx <= w_idx;
            if (w_acc) r_wdata <= write_data;
            if (w_acc)                                      r_cnt <= (wr ? CW'(WR_LATENCY - 1) : CW'(RD_LATENCY - 1)) + w_extra;
            else if (w_nxt == REFRESH && r_state != REFRESH) r_cnt <= CW'(REFRESH_CYCLES - 1);
            else if (!w_done)                                r_cnt <= r_cnt - 1'b1;
        end
    end

    // storage: INIT clears one word per cycle, writes land on the wvalid edge, reads snapshot at acceptance
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_idx] <= (r_state == INIT) ? '0 : r_wdata;
        if (w_acc)    r_rbuf <= r_mem[w_idx];
    end
endmodule

// File: doc/ctrl_mem_responder.md
Name: ctrl_mem_responder

Overview:
- Synthesizable subordinate (responder) for the controller-side request interface driven by masters of sdram_core: addr, write_data, wr, rd, rdy, wvalid, rvalid, read_data.
- Backs the interface with a small on-chip word memory and mimics SDRAM timing: init blackout, fixed access latency, periodic refresh stalls.
- Lets bus masters and traffic generators be exercised without the SDRAM controller or device model.

Parameters:
ADDR_WIDTH, 32, request address width (byte address)
DATA_WIDTH, 32, data word width; must be a multiple of 8
MEM_ADDR_WIDTH, 10, log2 of memory depth in words
WR_LATENCY, 3, cycles from write acceptance edge to wvalid pulse; min 1
RD_LATENCY, 5, cycles from read acceptance edge to rvalid pulse; min 1
REFRESH_PERIOD, 390, cycles between refresh requests
REFRESH_CYCLES, 4, cycles rdy is held low per refresh

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
addr  in  ADDR_WIDTH  request byte address
write_data  in  DATA_WIDTH  write data
wr  in  1  write request, held until accepted
rd  in  1  read request, held until accepted
rdy  out  1  responder can accept a request this edge
wvalid  out  1  one-cycle write-complete pulse
rvalid  out  1  one-cycle read-data-valid pulse
read_data  out  DATA_WIDTH  read data; stable from rvalid until the next rvalid

Behaviour:
- Reset is asynchronous and active-high. During and after reset: rdy=0, wvalid=0, rvalid=0, read_data=0, state=INIT, refresh counter=0, refresh pending=0.
- Word index = addr[MEM_ADDR_WIDTH+B-1:B], where B = log2(DATA_WIDTH/8). Byte-offset bits and upper bits are ignored, so addresses alias modulo the memory depth.
- States: INIT, IDLE, WRITE, READ, REFRESH.
- INIT: writes 0 to every word, one per cycle (2^MEM_ADDR_WIDTH cycles), then goes to IDLE.
- rdy is registered; it is 1 only in IDLE with no refresh pending.
- Acceptance: a rising edge with rdy=1 and (wr|rd)=1.
  - On that edge addr and write_data are latched, the latency counter is loaded, and the state moves to WRITE or READ.
  - rdy is 0 from the next cycle, so a request held one extra cycle is never accepted twice.
- wr and rd both high at acceptance: the write is accepted and rd is ignored; the master must reissue the read.
- WRITE: after WR_LATENCY cycles, wvalid=1 for one cycle and the memory word is updated on that same edge. The next state is IDLE, or REFRESH if a refresh is pending.
- READ: the memory is sampled at acceptance. After RD_LATENCY cycles, rvalid=1 for one cycle and read_data is updated in the same cycle. Next state as for WRITE.
- Back-to-back: the earliest next acceptance is the edge after the cycle in which rdy returns to 1. Minimum issue interval is latency+2 cycles.
- Refresh counter:
  - Runs free from leaving INIT and wraps at REFRESH_PERIOD-1.
  - On wrap it sets the pending flag; a second wrap while already pending is lost (no queuing).
  - In IDLE, pending forces rdy=0 from the next cycle and the state moves to REFRESH.
  - REFRESH lasts REFRESH_CYCLES cycles, clears pending, then returns to IDLE.
- Wrap on the same edge as an acceptance: the request proceeds and the refresh runs after its completion.
- wr/rd deasserted before acceptance: no effect, no pulse is emitted.
- Reset mid-operation: the in-flight request is dropped with no pulse, and INIT re-clears the memory.

Optional Feature:
CTRL_RESP_RAND_STALL_EN:
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle. At each acceptance, LFSR[2:0] extra cycles (0-7) are added to that request's latency.
- Undefined: latency is exactly WR_LATENCY or RD_LATENCY and no LFSR logic exists.

Test Plan:
- Reset with defaults -> rdy=0 for 1024 cycles after rst falls, then rdy=1. A read of addr 0x0000_0010 returns rvalid with read_data=0.
- Write 0xDEADBEEF to 0x0000_0404 (wr held through the edge after acceptance) -> single wvalid 3 cycles after acceptance, no second acceptance. Read 0x0000_0404 -> rvalid 5 cycles after acceptance with 0xDEADBEEF.
- Write 0x12345678 to 0x0000_1004, then read 0x0000_0004 -> 0x12345678 (aliasing, word index 1).
- Assert wr and rd together at addr 0x8 with data 0xA5A5A5A5 -> only wvalid pulses; a later read of 0x8 returns 0xA5A5A5A5.
- Continuous write/read traffic across the 390-cycle refresh wrap -> rdy low for exactly 4 cycles after the in-flight op completes; no data corruption, no lost pulses.
- Assert rst during READ latency -> no rvalid pulse; INIT repeats; the earlier written word now reads back 0.
